// File: rtl/sqr_sgn_arb_pkg.sv
// Shared types and helpers for the shared signed-squarer arbiter.
//   speed_e         : squarer implementation choice (SLOW / FAST)
//   sqr_arb_slot_e  : occupancy state of the response register
//   id_w()          : requester-ID width, never less than 1 bit
package lau_pkg;

  typedef enum logic {
    SLOW = 1'b0,
    FAST = 1'b1
  } speed_e;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } sqr_arb_slot_e;

  function automatic int id_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sqr_sgn_arb_rr_arb.sv
// Round-robin grant generator.
//   req   : request vector
//   ptr   : search start index (0..N-1)
//   en    : allow a grant this cycle
//   grant : one-hot grant (zero when !en or no request)
//   idx   : index of the selected requester (valid when any=1)
//   any   : at least one request present
// The lowest request at or above ptr wins; otherwise the search wraps to
// the lowest request overall.
module rr_arb #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [N-1:0] ge_mask;
  logic [N-1:0] hi_req;
  logic [N-1:0] sel_vec;

  for (genvar gi = 0; gi < N; gi++) begin : g_mask
    assign ge_mask[gi] = (gi >= int'(ptr));
  end

  assign hi_req  = req & ge_mask;
  assign any     = |req;
  assign sel_vec = (|hi_req) ? hi_req : req;

  always_comb begin
    idx = '0;
    // Descending scan so the lowest set bit is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (sel_vec[i]) idx = IW'(i);
    end
  end

  always_comb begin
    grant = '0;
    if (en && any) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/sqr_sgn_arb_sqr.sv
// Combinational signed squarer, p = x*x, exact in 2*width bits.
//   x : signed operand, width bits
//   p : square, 2*width bits (always non-negative)
// speed selects a direct signed multiply (FAST) or a magnitude-squared
// form (SLOW) that maps onto a narrower unsigned multiplier.
module lau_sqr_sgn
  import lau_pkg::*;
#(
  parameter int     width = 8,
  parameter speed_e speed = FAST
) (
  input  logic [width-1:0]   x,
  output logic [2*width-1:0] p
);

  if (speed == FAST) begin : g_fast
    logic signed [2*width-1:0] sx;
    assign sx = {{width{x[width-1]}}, x};
    assign p  = $unsigned(sx * sx);
  end else begin : g_slow
    // |x| fits in width unsigned bits, including |-2^(width-1)|.
    logic [width-1:0]   mag;
    logic [2*width-1:0] mag_ext;
    assign mag     = x[width-1] ? (~x + 1'b1) : x;
    assign mag_ext = {{width{1'b0}}, mag};
    assign p       = mag_ext * mag_ext;
  end

endmodule

// File: rtl/sqr_sgn_arb.sv
// Shared signed squarer with round-robin arbitration among numReq clients.
//   CLK, RST           : clock, asynchronous active-high reset
//   ReqValid/ReqReady  : per-requester operand handshake (ReqReady one-hot/0)
//   ReqX               : operands, requester i at [i*width +: width]
//   RspValid/RspReady  : registered result handshake
//   RspP, RspId        : signed square and requester index of the result
//   Busy               : some stage holds valid data
//   DoneCnt            : completed response handshakes, wraps at 16 bits
// Optional macro SQR_SGN_ARB_PIPE_EN inserts a stage-1 operand register
// ahead of the squarer (latency 2 instead of 1, same throughput).
module sqr_sgn_arb
  import lau_pkg::*;
#(
  parameter int     width  = 8,
  parameter int     numReq = 4,
  parameter speed_e speed  = FAST,
  localparam int    idW    = id_w(numReq)
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [numReq-1:0]       ReqValid,
  output logic [numReq-1:0]       ReqReady,
  input  logic [numReq*width-1:0] ReqX,
  output logic                    RspValid,
  input  logic                    RspReady,
  output logic [2*width-1:0]      RspP,
  output logic [idW-1:0]          RspId,
  output logic                    Busy,
  output logic [15:0]             DoneCnt
);

  sqr_arb_slot_e      slot_q, slot_d;
  logic [2*width-1:0] rsp_p_q, rsp_p_d;
  logic [idW-1:0]     rsp_id_q, rsp_id_d;
  logic [idW-1:0]     ptr_q, ptr_d;
  logic [15:0]        done_cnt_q, done_cnt_d;

  logic [numReq-1:0]  arb_grant;
  logic [idW-1:0]     arb_idx;
  logic               arb_any;
  logic               arb_en;
  logic               accept;
  logic               drain;
  logic               out_free;
  logic               can_accept;
  logic               load;
  logic [idW-1:0]     load_id;
  logic [width-1:0]   sel_x;
  logic [width-1:0]   sq_x;
  logic [2*width-1:0] sq_p;
  logic               stage_busy;

  assign drain    = (slot_q == FULL) && RspReady;
  assign out_free = (slot_q == EMPTY) || drain;

  // Grants are suppressed while reset is held so ReqReady reads 0.
  assign arb_en = can_accept && !RST;
  assign accept = arb_en && arb_any;

  rr_arb #(
    .N  (numReq),
    .IW (idW)
  ) u_rr_arb (
    .req   (ReqValid),
    .ptr   (ptr_q),
    .en    (arb_en),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  assign ReqReady = arb_grant;

  always_comb begin
    sel_x = '0;
    for (int i = 0; i < numReq; i++) begin
      if (arb_idx == idW'(i)) sel_x = ReqX[i*width +: width];
    end
  end

`ifdef SQR_SGN_ARB_PIPE_EN
  logic               s1_valid_q, s1_valid_d;
  logic [width-1:0]   s1_x_q, s1_x_d;
  logic [idW-1:0]     s1_id_q, s1_id_d;
  logic               s1_adv;

  assign s1_adv     = s1_valid_q && out_free;
  assign can_accept = !s1_valid_q || s1_adv;
  assign sq_x       = s1_x_q;
  assign load       = s1_adv;
  assign load_id    = s1_id_q;
  assign stage_busy = s1_valid_q;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_x_d     = s1_x_q;
    s1_id_d    = s1_id_q;
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_x_d     = sel_x;
      s1_id_d    = arb_idx;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1_valid_q <= 1'b0;
      s1_x_q     <= '0;
      s1_id_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_x_q     <= s1_x_d;
      s1_id_q    <= s1_id_d;
    end
  end
`else
  assign can_accept = out_free;
  assign sq_x       = sel_x;
  assign load       = accept;
  assign load_id    = arb_idx;
  assign stage_busy = 1'b0;
`endif

  lau_sqr_sgn #(
    .width (width),
    .speed (speed)
  ) u_sqr (
    .x (sq_x),
    .p (sq_p)
  );

  always_comb begin
    slot_d     = slot_q;
    rsp_p_d    = rsp_p_q;
    rsp_id_d   = rsp_id_q;
    ptr_d      = ptr_q;
    done_cnt_d = done_cnt_q + 16'(drain);
    // A load can only happen when the slot is empty or draining, so
    // loading covers both EMPTY->FULL and the no-bubble FULL->FULL refill.
    if (load) begin
      slot_d   = FULL;
      rsp_p_d  = sq_p;
      rsp_id_d = load_id;
    end else if (drain) begin
      slot_d = EMPTY;
    end
    if (accept) begin
      ptr_d = (arb_idx == idW'(numReq - 1)) ? '0 : arb_idx + 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      slot_q     <= EMPTY;
      rsp_p_q    <= '0;
      rsp_id_q   <= '0;
      ptr_q      <= '0;
      done_cnt_q <= '0;
    end else begin
      slot_q     <= slot_d;
      rsp_p_q    <= rsp_p_d;
      rsp_id_q   <= rsp_id_d;
      ptr_q      <= ptr_d;
      done_cnt_q <= done_cnt_d;
    end
  end

  assign RspValid = (slot_q == FULL);
  assign RspP     = rsp_p_q;
  assign RspId    = rsp_id_q;
  assign Busy     = RspValid || stage_busy;
  assign DoneCnt  = done_cnt_q;

endmodule

// File: tb/tb_sqr_sgn_arb.sv
// Self-checking bench for sqr_sgn_arb (width=8, numReq=4).
// Inputs change 1 time unit after the rising edge; a negedge monitor
// records accepted operands into a scoreboard and checks every response.
module tb_sqr_sgn_arb;

  localparam int W   = 8;
  localparam int N   = 4;
  localparam int IW  = 2;
`ifdef SQR_SGN_ARB_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct packed {
    logic [IW-1:0]  id;
    logic [2*W-1:0] p;
  } exp_t;

  logic           CLK = 1'b0;
  logic           RST = 1'b1;
  logic [N-1:0]   ReqValid = '0;
  logic [N-1:0]   ReqReady;
  logic [N*W-1:0] ReqX = '0;
  logic           RspValid;
  logic           RspReady = 1'b0;
  logic [2*W-1:0] RspP;
  logic [IW-1:0]  RspId;
  logic           Busy;
  logic [15:0]    DoneCnt;

  sqr_sgn_arb #(.width(W), .numReq(N)) dut (
    .CLK(CLK), .RST(RST), .ReqValid(ReqValid), .ReqReady(ReqReady),
    .ReqX(ReqX), .RspValid(RspValid), .RspReady(RspReady), .RspP(RspP),
    .RspId(RspId), .Busy(Busy), .DoneCnt(DoneCnt)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  bit verbose = 1'b1;

  exp_t        sb[$];
  int          grant_log[$];
  exp_t        rsp_log[$];
  int          acc_cnt = 0;
  int          rsp_cnt = 0;
  logic [N-1:0] acc_mask = '0;
  logic [15:0] done_model = '0;
  bit          hold_pend = 1'b0;
  logic [2*W-1:0] hold_p;
  logic [IW-1:0]  hold_id;

  int          mode[N];
  logic [W-1:0] fix_x[N];
  int          left[N];

  function automatic logic [2*W-1:0] sq_model(input logic [W-1:0] x);
    logic signed [2*W-1:0] a;
    a = $signed(x);
    return $unsigned(a * a);
  endfunction

  // Scoreboard monitor, evaluated half a cycle before each active edge.
  always @(negedge CLK) begin
    if (RST) begin
      acc_mask   = '0;
      hold_pend  = 1'b0;
      done_model = '0;
    end else begin
      checks++;
      if (DoneCnt !== done_model) begin
        errors++;
        $display("FAIL donecnt: got %h expected %h", DoneCnt, done_model);
      end
      if (hold_pend) begin
        checks++;
        if (RspP !== hold_p || RspId !== hold_id) begin
          errors++;
          $display("FAIL hold: got p=%h id=%0d expected p=%h id=%0d",
                   RspP, RspId, hold_p, hold_id);
        end
      end
      checks++;
      if (!$onehot0(ReqReady)) begin
        errors++;
        $display("FAIL ready_onehot: got %b expected one-hot or zero", ReqReady);
      end
      if (RspValid && RspReady) begin
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rsp: got p=%h id=%0d expected no response",
                   RspP, RspId);
        end else begin
          e = sb.pop_front();
          if (RspP !== e.p || RspId !== e.id) begin
            errors++;
            $display("FAIL rsp: got p=%h id=%0d expected p=%h id=%0d",
                     RspP, RspId, e.p, e.id);
          end
        end
        rsp_log.push_back('{id: RspId, p: RspP});
        if (verbose) $display("rsp  id=%0d p=%h", RspId, RspP);
        rsp_cnt++;
        done_model = done_model + 16'd1;
      end
      hold_pend = RspValid && !RspReady;
      hold_p    = RspP;
      hold_id   = RspId;
      acc_mask  = ReqValid & ReqReady;
      for (int i = 0; i < N; i++) begin
        if (acc_mask[i]) begin
          sb.push_back('{id: IW'(i), p: sq_model(ReqX[i*W +: W])});
          grant_log.push_back(i);
          acc_cnt++;
          if (verbose) $display("req  id=%0d x=%h", i, ReqX[i*W +: W]);
        end
      end
    end
  end

  task automatic set_req(input int i, input int m, input logic [W-1:0] x,
                         input int n);
    mode[i]  = m;
    fix_x[i] = x;
    left[i]  = n;
    if (m != 0 && n != 0) begin
      ReqValid[i]     = 1'b1;
      ReqX[i*W +: W]  = (m == 2) ? W'($urandom) : x;
    end else begin
      ReqValid[i] = 1'b0;
    end
  endtask

  task automatic idle_all();
    for (int i = 0; i < N; i++) set_req(i, 0, '0, 0);
  endtask

  // One clock; requesters whose operand was taken refill or drop.
  task automatic step();
    @(posedge CLK);
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc_mask[i]) begin
        if (left[i] > 0) left[i]--;
        if (left[i] == 0) ReqValid[i] = 1'b0;
        else if (mode[i] == 2) ReqX[i*W +: W] = W'($urandom);
        else ReqX[i*W +: W] = fix_x[i];
      end
    end
  endtask

  task automatic drain_all();
    int n = 0;
    RspReady = 1'b1;
    while ((sb.size() != 0 || Busy) && n < 100) begin
      step();
      n++;
    end
    checks++;
    if (sb.size() != 0 || Busy) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
    end
  endtask

  task automatic reset_dut();
    RST = 1'b1;
    idle_all();
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    sb.delete();
    grant_log.delete();
    rsp_log.delete();
  endtask

  task automatic test_reset();
    reset_dut();
    for (int c = 0; c < 10; c++) begin
      step();
      checks++;
      if (RspValid !== 1'b0 || ReqReady !== '0 || Busy !== 1'b0 ||
          DoneCnt !== 16'd0) begin
        errors++;
        $display("FAIL reset_idle: got v=%b rdy=%b busy=%b cnt=%h expected 0 0 0 0",
                 RspValid, ReqReady, Busy, DoneCnt);
      end
    end
  endtask

  task automatic test_single();
    RspReady = 1'b1;
    set_req(2, 1, 8'h80, 1);
    #1;
    checks++;
    if (ReqReady !== 4'b0100) begin
      errors++;
      $display("FAIL single_ready: got %b expected 0100", ReqReady);
    end
    step();
    repeat (LAT - 1) step();
    checks++;
    if (RspValid !== 1'b1 || RspP !== 16'h4000 || RspId !== 2'd2) begin
      errors++;
      $display("FAIL single_rsp: got v=%b p=%h id=%0d expected 1 4000 2",
               RspValid, RspP, RspId);
    end
    step();
    checks++;
    if (DoneCnt !== 16'd1 || RspValid !== 1'b0) begin
      errors++;
      $display("FAIL single_done: got cnt=%h v=%b expected 0001 0", DoneCnt, RspValid);
    end
  endtask

  task automatic test_round_robin();
    logic [2*W-1:0] exp_p[4];
    logic [W-1:0]   xs[4];
    exp_p = '{16'h0001, 16'h0009, 16'h3F01, 16'h0004};
    xs    = '{8'hFF, 8'h03, 8'h7F, 8'hFE};
    reset_dut();
    RspReady = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 1, xs[i], -1);
    repeat (12) step();
    idle_all();
    drain_all();
    checks++;
    if (grant_log.size() != 12) begin
      errors++;
      $display("FAIL rr_no_idle: got %0d grants expected 12", grant_log.size());
    end
    for (int k = 0; k < 12 && k < grant_log.size(); k++) begin
      checks++;
      if (grant_log[k] != (k % 4)) begin
        errors++;
        $display("FAIL rr_order: got %0d expected %0d at %0d", grant_log[k], k % 4, k);
      end
    end
    for (int k = 0; k < 4 && k < rsp_log.size(); k++) begin
      checks++;
      if (rsp_log[k].p !== exp_p[k] || rsp_log[k].id !== IW'(k)) begin
        errors++;
        $display("FAIL rr_result: got p=%h id=%0d expected p=%h id=%0d",
                 rsp_log[k].p, rsp_log[k].id, exp_p[k], k);
      end
    end
  endtask

  task automatic test_backpressure();
    int acc0, rsp0;
    reset_dut();
    acc0 = acc_cnt;
    rsp0 = rsp_cnt;
    RspReady = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 2, '0, -1);
    repeat (6) step();
    RspReady = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      checks++;
      if (ReqReady !== '0 || RspValid !== 1'b1) begin
        errors++;
        $display("FAIL stall: got rdy=%b v=%b expected 0000 1", ReqReady, RspValid);
      end
    end
    RspReady = 1'b1;
    repeat (6) step();
    idle_all();
    drain_all();
    checks++;
    if ((acc_cnt - acc0) != (rsp_cnt - rsp0) || (acc_cnt - acc0) < 10) begin
      errors++;
      $display("FAIL bp_count: got %0d responses expected %0d accepts",
               rsp_cnt - rsp0, acc_cnt - acc0);
    end
  endtask

  task automatic test_reset_mid();
    RspReady = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, 2, '0, -1);
    repeat (4) step();
    @(negedge CLK);
    #2;
    RST = 1'b1;
    #1;
    checks++;
    if (RspValid !== 1'b0 || RspP !== '0 || RspId !== '0 || Busy !== 1'b0 ||
        DoneCnt !== 16'd0 || ReqReady !== '0) begin
      errors++;
      $display("FAIL reset_async: got v=%b p=%h id=%0d busy=%b cnt=%h rdy=%b expected all 0",
               RspValid, RspP, RspId, Busy, DoneCnt, ReqReady);
    end
    idle_all();
    set_req(1, 1, 8'h05, 1);
    set_req(3, 1, 8'hFA, 1);
    sb.delete();
    grant_log.delete();
    #1;
    checks++;
    if (ReqReady !== '0) begin
      errors++;
      $display("FAIL reset_ready: got %b expected 0000", ReqReady);
    end
    repeat (2) @(posedge CLK);
    #2;
    RST = 1'b0;
    RspReady = 1'b1;
    for (int n = 0; n < 10 && grant_log.size() < 2; n++) step();
    checks++;
    if (grant_log.size() < 2 || grant_log[0] != 1 || grant_log[1] != 3) begin
      errors++;
      $display("FAIL reset_first_grant: got %0d grants first=%0d expected 1 then 3",
               grant_log.size(), (grant_log.size() > 0) ? grant_log[0] : -1);
    end
    drain_all();
  endtask

  task automatic test_wrap();
    int steps = 0;
    int rsp0;
    reset_dut();
    verbose  = 1'b0;
    rsp0     = rsp_cnt;
    RspReady = 1'b1;
    set_req(0, 2, '0, 65536);
    while (left[0] != 0 && steps < 70000) begin
      step();
      steps++;
    end
    checks++;
    if (steps != 65536) begin
      errors++;
      $display("FAIL wrap_throughput: got %0d cycles expected 65536", steps);
    end
    drain_all();
    checks++;
    if (DoneCnt !== 16'd0 || (rsp_cnt - rsp0) != 65536) begin
      errors++;
      $display("FAIL wrap: got cnt=%h rsps=%0d expected 0000 65536",
               DoneCnt, rsp_cnt - rsp0);
    end
    verbose = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      mode[i]  = 0;
      fix_x[i] = '0;
      left[i]  = 0;
    end
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
